// File: rtl/csat_enum_ctrl_if.sv
// Host/netlist side bundle of csat_enum_ctrl: search control, netlist drive/sense and results.
interface csat_enum_ctrl_if #(
    parameter int unsigned N_VARS = 7
);
    logic              start;
    logic              abort;
    logic              sat_in;
    logic [N_VARS-1:0] assign_out;
    logic              busy;
    logic              done;
    logic              found;
    logic [N_VARS-1:0] model;
    logic [N_VARS:0]   sol_count;

    modport master (
        output start, abort, sat_in,
        input  assign_out, busy, done, found, model, sol_count
    );

    modport slave (
        input  start, abort, sat_in,
        output assign_out, busy, done, found, model, sol_count
    );
endinterface

// File: rtl/csat_enum_ctrl.sv
// Exhaustive-search circuit-SAT controller: sweeps candidates, samples sat_in after a settle window.
// Optional macro CSAT_COUNT_ALL_EN: sweep the full space and count every satisfying candidate.
module csat_enum_ctrl #(
    parameter int unsigned N_VARS = 7,
    parameter int unsigned SETTLE = 1
) (
    input logic             clk,
    input logic             rst_n,
    csat_enum_ctrl_if.slave bus
);
    localparam int unsigned   CW        = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t            state, state_n;
    logic [N_VARS-1:0] asg, asg_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              fnd, fnd_n;
    logic [N_VARS-1:0] mdl, mdl_n;
    logic [N_VARS:0]   sol, sol_n;

`ifdef CSAT_COUNT_ALL_EN
    localparam logic [N_VARS:0] SOL_MAX = {1'b1, {N_VARS{1'b0}}};
`endif

    always_comb begin
        state_n = state;
        asg_n   = asg;
        cnt_n   = cnt;
        fnd_n   = fnd;
        mdl_n   = mdl;
        sol_n   = sol;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    asg_n   = '0;
                    cnt_n   = SETTLE_LD;
                    fnd_n   = 1'b0;
                    mdl_n   = '0;
                    sol_n   = '0;
                end
            end
            RUN: begin
                // Abort outranks a sat_in sample taken in the same cycle.
                if (bus.abort) begin
                    state_n = IDLE;
                    fnd_n   = 1'b0;
                    mdl_n   = '0;
                    sol_n   = '0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
`ifdef CSAT_COUNT_ALL_EN
                    if (bus.sat_in) begin
                        if (sol == '0) begin
                            mdl_n = asg;
                        end
                        if (sol != SOL_MAX) begin
                            sol_n = sol + 1'b1;
                        end
                        fnd_n = 1'b1;
                    end
                    if (asg == '1) begin
                        state_n = FIN;
                    end else begin
                        asg_n = asg + 1'b1;
                        cnt_n = SETTLE_LD;
                    end
`else
                    if (bus.sat_in) begin
                        state_n = FIN;
                        mdl_n   = asg;
                        fnd_n   = 1'b1;
                        sol_n   = {{N_VARS{1'b0}}, 1'b1};
                    end else if (asg == '1) begin
                        state_n = FIN;
                    end else begin
                        asg_n = asg + 1'b1;
                        cnt_n = SETTLE_LD;
                    end
`endif
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            asg   <= '0;
            cnt   <= '0;
            fnd   <= 1'b0;
            mdl   <= '0;
            sol   <= '0;
        end else begin
            state <= state_n;
            asg   <= asg_n;
            cnt   <= cnt_n;
            fnd   <= fnd_n;
            mdl   <= mdl_n;
            sol   <= sol_n;
        end
    end

    assign bus.assign_out = asg;
    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == FIN);
    assign bus.found      = fnd;
    assign bus.model      = mdl;
    assign bus.sol_count  = sol;
endmodule

// File: tb/tb_csat_enum_ctrl.sv
// Scoreboard bench for csat_enum_ctrl: three instances (25-factor netlist, UNSAT netlist, 3-model netlist).
module tb_csat_enum_ctrl;
    localparam int unsigned NV = 7;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csat_enum_ctrl_if #(.N_VARS(NV)) ba ();
    csat_enum_ctrl_if #(.N_VARS(NV)) bb ();
    csat_enum_ctrl_if #(.N_VARS(NV)) bc ();

    csat_enum_ctrl #(.N_VARS(NV), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
    csat_enum_ctrl #(.N_VARS(NV), .SETTLE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));
    csat_enum_ctrl #(.N_VARS(NV), .SETTLE(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bc));

    // 4x3 factorization netlist for 25: {b[2:0], a[3:0]}
    function automatic logic fac25(input logic [NV-1:0] v);
        return (int'(v[3:0]) * int'(v[6:4])) == 25;
    endfunction

    assign ba.sat_in = fac25(ba.assign_out);
    assign bb.sat_in = 1'b0;
    assign bc.sat_in = (bc.assign_out == 7'd3) || (bc.assign_out == 7'd85) || (bc.assign_out == 7'd127);

    typedef struct {
        int unsigned     e0;
        int unsigned     lat;
        logic            found;
        logic [NV-1:0]   model;
        logic [NV:0]     cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic cmp_exp(input string tag, input exp_t e, input logic f,
                           input logic [NV-1:0] m, input logic [NV:0] c);
        chk({tag, "_done_latency"}, cyc - e.e0, e.lat);
        chk({tag, "_found"}, 32'(f), 32'(e.found));
        chk({tag, "_model"}, 32'(m), 32'(e.model));
        chk({tag, "_sol_count"}, 32'(c), 32'(e.cnt));
    endtask

    task automatic chk_zero(input string tag, input logic [NV-1:0] asg, input logic b,
                            input logic d, input logic f, input logic [NV-1:0] m,
                            input logic [NV:0] c);
        chk({tag, "_assign_out"}, 32'(asg), 0);
        chk({tag, "_busy"}, 32'(b), 0);
        chk({tag, "_done"}, 32'(d), 0);
        chk({tag, "_found"}, 32'(f), 0);
        chk({tag, "_model"}, 32'(m), 0);
        chk({tag, "_sol_count"}, 32'(c), 0);
    endtask

    // Monitors: every done pulse is matched against the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && ba.done) begin
            if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
            else cmp_exp("a", qa.pop_front(), ba.found, ba.model, ba.sol_count);
        end
    end

    always @(negedge clk) begin
        if (rst_n && bb.done) begin
            if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
            else cmp_exp("b", qb.pop_front(), bb.found, bb.model, bb.sol_count);
        end
    end

    always @(negedge clk) begin
        if (rst_n && bc.done) begin
            if (qc.size() == 0) chk("c_unexpected_done", 1, 0);
            else cmp_exp("c", qc.pop_front(), bc.found, bc.model, bc.sol_count);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int unsigned e0;
        int          i;

        ba.start = 1'b0; ba.abort = 1'b0;
        bb.start = 1'b0; bb.abort = 1'b0;
        bc.start = 1'b0; bc.abort = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst_a", ba.assign_out, ba.busy, ba.done, ba.found, ba.model, ba.sol_count);
        chk_zero("rst_b", bb.assign_out, bb.busy, bb.done, bb.found, bb.model, bb.sol_count);
        chk_zero("rst_c", bc.assign_out, bc.busy, bc.done, bc.found, bc.model, bc.sol_count);
        @(negedge clk) rst_n = 1'b1;

        // 25-factor run: model 0x55 at index 85, latency 86*2
        @(negedge clk) ba.start = 1'b1;
        @(posedge clk); #1;
        ba.start = 1'b0;
        e0 = cyc;
        qa.push_back('{e0: e0, lat: 172, found: 1'b1, model: 7'h55, cnt: 8'd1});
        chk("t1_busy", 32'(ba.busy), 1);
        chk("t1_cand0", 32'(ba.assign_out), 0);
        i = 0;
        while (!ba.done && i < 400) begin @(negedge clk); i++; end
        if (!ba.done) chk("t1_done_timeout", 0, 1);
        @(posedge clk); #1;
        chk("t1_done_one_cycle", 32'(ba.done), 0);
        chk("t1_busy_after", 32'(ba.busy), 0);
        chk("t1_found_held", 32'(ba.found), 1);
        chk("t1_model_held", 32'(ba.model), 32'h55);

        // UNSAT sweep with SETTLE=0: one candidate per cycle, done after 128
        @(negedge clk) bb.start = 1'b1;
        @(posedge clk); #1;
        bb.start = 1'b0;
        e0 = cyc;
        qb.push_back('{e0: e0, lat: 128, found: 1'b0, model: 7'h00, cnt: 8'd0});
        for (int k = 0; k < 128; k++) begin
            chk($sformatf("t2_step%0d", k), 32'(bb.assign_out), 32'(k));
            @(posedge clk); #1;
        end
        chk("t2_done", 32'(bb.done), 1);
        @(posedge clk); #1;
        chk("t2_done_one_cycle", 32'(bb.done), 0);
        chk("t2_busy_after", 32'(bb.busy), 0);
        chk("t2_assign_held", 32'(bb.assign_out), 127);

        // Three-model netlist, SETTLE=2
        @(negedge clk) bc.start = 1'b1;
        @(posedge clk); #1;
        bc.start = 1'b0;
        e0 = cyc;
`ifdef CSAT_COUNT_ALL_EN
        qc.push_back('{e0: e0, lat: 384, found: 1'b1, model: 7'd3, cnt: 8'd3});
`else
        qc.push_back('{e0: e0, lat: 12, found: 1'b1, model: 7'd3, cnt: 8'd1});
`endif
        i = 0;
        while (!bc.done && i < 1000) begin @(negedge clk); i++; end
        if (!bc.done) chk("t5_done_timeout", 0, 1);
        @(posedge clk); #1;

        // Abort during candidate 40 of the 25-factor run
        @(negedge clk) ba.start = 1'b1;
        @(posedge clk); #1;
        ba.start = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("t3_cand40", 32'(ba.assign_out), 40);
        @(negedge clk) ba.abort = 1'b1;
        @(posedge clk); #1;
        ba.abort = 1'b0;
        chk("t3_busy", 32'(ba.busy), 0);
        chk("t3_done", 32'(ba.done), 0);
        chk("t3_found", 32'(ba.found), 0);
        chk("t3_model", 32'(ba.model), 0);
        chk("t3_sol_count", 32'(ba.sol_count), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_still_idle", 32'(ba.busy), 0);

        // Restart with start and abort together while idle: start wins
        @(negedge clk) begin ba.start = 1'b1; ba.abort = 1'b1; end
        @(posedge clk); #1;
        ba.start = 1'b0; ba.abort = 1'b0;
        e0 = cyc;
        qa.push_back('{e0: e0, lat: 172, found: 1'b1, model: 7'h55, cnt: 8'd1});
        chk("t3_restart_busy", 32'(ba.busy), 1);
        chk("t3_restart_cand0", 32'(ba.assign_out), 0);
        i = 0;
        while (!ba.done && i < 400) begin @(negedge clk); i++; end
        if (!ba.done) chk("t3_restart_timeout", 0, 1);
        @(posedge clk); #1;

        // Repeated starts during RUN are ignored; reset at cycle 50 clears everything
        @(negedge clk) ba.start = 1'b1;
        @(posedge clk); #1;
        ba.start = 1'b0;
        for (int c = 1; c < 50; c++) begin
            @(negedge clk) ba.start = ((c % 7) == 3);
            @(posedge clk); #1;
        end
        ba.start = 1'b0;
        chk("t4_cand24", 32'(ba.assign_out), 24);
        chk("t4_busy", 32'(ba.busy), 1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk_zero("t4_rst_a", ba.assign_out, ba.busy, ba.done, ba.found, ba.model, ba.sol_count);
        chk_zero("t4_rst_b", bb.assign_out, bb.busy, bb.done, bb.found, bb.model, bb.sol_count);
        chk_zero("t4_rst_c", bc.assign_out, bc.busy, bc.done, bc.found, bc.model, bc.sol_count);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t4_idle_after_reset", 32'(ba.busy), 0);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
